// File: rtl/huff_coef_unpack_pkg.sv
// Shared constants for the coefficient unpack stage.
//   COEF_W_DEF : default coefficient width
//   NCOMP_DEF  : default number of DC predictors
//   ZZ_NAT     : zigzag index -> natural (row-major) address
package huff_coef_unpack_pkg;

  localparam int unsigned COEF_W_DEF = 16;
  localparam int unsigned NCOMP_DEF  = 3;
  localparam int unsigned POS_W      = 7;

  localparam logic [5:0] ZZ_NAT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/huff_coef_unpack_if.sv
// Bus between HuffDecoder/IDCT side (master) and the unpack stage (slave).
//   symbol side : sym_valid, huff_size, data_zero, data_len, data_stream,
//                 data_type, quan_tb_sel, clr_pred -> ; <- stall, err
//   reader side : rd_addr, blk_release -> ; <- blk_valid, blk_comp, blk_qtb, rd_data
interface huff_coef_unpack_if
  import huff_coef_unpack_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF
);
  logic              sym_valid;
  logic [3:0]        huff_size;
  logic [3:0]        data_zero;
  logic [3:0]        data_len;
  logic [31:0]       data_stream;
  logic [1:0]        data_type;
  logic              quan_tb_sel;
  logic              clr_pred;
  logic              stall;
  logic              blk_valid;
  logic [1:0]        blk_comp;
  logic              blk_qtb;
  logic [5:0]        rd_addr;
  logic [COEF_W-1:0] rd_data;
  logic              blk_release;
  logic              err;

  modport master (
    output sym_valid, huff_size, data_zero, data_len, data_stream, data_type,
           quan_tb_sel, clr_pred, rd_addr, blk_release,
    input  stall, blk_valid, blk_comp, blk_qtb, rd_data, err
  );

  modport slave (
    input  sym_valid, huff_size, data_zero, data_len, data_stream, data_type,
           quan_tb_sel, clr_pred, rd_addr, blk_release,
    output stall, blk_valid, blk_comp, blk_qtb, rd_data, err
  );
endinterface

// File: rtl/huff_coef_extend.sv
// Magnitude-bit extraction after the Huffman code plus JPEG EXTEND.
//   i_huff_size   : code length minus 1
//   i_data_len    : magnitude bit count (0..15)
//   i_data_stream : window, MSB first, aligned at the code start
//   o_coef_c      : sign-extended value (combinational)
module huff_coef_extend
  import huff_coef_unpack_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF
) (
  input  logic [3:0]        i_huff_size,
  input  logic [3:0]        i_data_len,
  input  logic [31:0]       i_data_stream,
  output logic [COEF_W-1:0] o_coef_c
);
  logic [4:0]  w_shamt;
  logic [15:0] w_hi;
  logic [15:0] w_raw;
  logic [15:0] w_mask;
  logic [15:0] w_top;
  logic [15:0] w_v;

  // Drop the code, keep the top 16 bits, right-align data_len of them.
  assign w_shamt = 5'(i_huff_size) + 5'd1;
  assign w_hi    = 16'((i_data_stream << w_shamt) >> 16);
  assign w_raw   = w_hi >> (5'd16 - 5'(i_data_len));

  // w_mask = 2^len-1; w_top isolates the value MSB (both 0 when len==0).
  assign w_mask  = 16'((17'd1 << i_data_len) - 17'd1);
  assign w_top   = w_mask ^ (w_mask >> 1);
  assign w_v     = ((w_raw & w_top) == 16'd0) ? (w_raw - w_mask) : w_raw;

  assign o_coef_c = COEF_W'($signed(w_v));
endmodule

// File: rtl/huff_coef_unpack.sv
// Coefficient unpack: DC prediction, run/size expansion, zigzag-to-natural
// writes into a ping-pong pair of 64-entry block buffers.
//   clk, rst   : clock, async active-low reset
//   bus.slave  : symbol input, stall/err, block read port
module huff_coef_unpack
  import huff_coef_unpack_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned NCOMP  = NCOMP_DEF
) (
  input logic               clk,
  input logic               rst,
  huff_coef_unpack_if.slave bus
);
  logic [POS_W-1:0]  r_pos;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [1:0]        r_full;
  logic [COEF_W-1:0] r_pred [NCOMP];
  logic [63:0]       r_mask [2];
  logic [COEF_W-1:0] r_mem  [2][64];
  logic [1:0]        r_bank_comp [2];
  logic              r_bank_qtb  [2];
  logic              r_blk_valid;
  logic [1:0]        r_blk_comp;
  logic              r_blk_qtb;
  logic [COEF_W-1:0] r_rd_data;
  logic              r_err;

  logic [COEF_W-1:0] w_v;
  logic [COEF_W-1:0] w_pred_sel;
  logic [COEF_W-1:0] w_dc;
  logic              w_stall, w_go, w_is_dc, w_dc_wr, w_ac, w_eob, w_zrl, w_rel, w_pred_ok;
  logic              w_ovf, w_wr_ac, w_finish, w_we, w_rd_bank_nxt;
  logic [POS_W-1:0]  w_p, w_pos_nxt;
  logic [1:0]        w_full_nxt;
  logic [5:0]        w_waddr;
  logic [COEF_W-1:0] w_wdata;

  huff_coef_extend #(.COEF_W(COEF_W)) u_extend (
    .i_huff_size   (bus.huff_size),
    .i_data_len    (bus.data_len),
    .i_data_stream (bus.data_stream),
    .o_coef_c      (w_v)
  );

  assign w_stall   = r_full[0] & r_full[1];
  assign w_go      = bus.sym_valid & ~w_stall;
  assign w_is_dc   = (r_pos == '0);
  assign w_dc_wr   = w_go & w_is_dc;
  assign w_ac      = w_go & ~w_is_dc;
  assign w_eob     = (bus.data_len == 4'd0) && (bus.data_zero == 4'd0);
  assign w_zrl     = (bus.data_len == 4'd0) && (bus.data_zero == 4'd15);
  assign w_rel     = bus.blk_release & r_blk_valid;
  assign w_pred_ok = (32'(bus.data_type) < NCOMP);

  // A restart pulse or an unpredicted component forces a zero predictor.
  assign w_pred_sel = (bus.clr_pred || !w_pred_ok) ? '0 : r_pred[bus.data_type];
  assign w_dc       = w_pred_sel + w_v;

  // Symbol decode, bank flag update and the single RAM write port.
  always_comb begin
    w_p           = w_zrl ? (r_pos + 7'd16) : (r_pos + 7'(bus.data_zero));
    w_ovf         = 1'b0;
    w_wr_ac       = 1'b0;
    w_finish      = 1'b0;
    w_pos_nxt     = r_pos;
    w_full_nxt    = r_full;
    w_rd_bank_nxt = r_rd_bank ^ w_rel;
    w_we          = 1'b0;
    w_waddr       = '0;
    w_wdata       = w_v;

    if (w_dc_wr) begin
      w_pos_nxt = 7'd1;
      w_we      = 1'b1;
      w_wdata   = w_dc;
    end else if (w_ac) begin
      if (w_eob) begin
        w_finish = 1'b1;
      end else if (w_p > 7'd63) begin
        w_ovf    = 1'b1;
        w_finish = 1'b1;
      end else if (w_zrl) begin
        w_pos_nxt = w_p;
      end else begin
        w_wr_ac   = 1'b1;
        w_we      = 1'b1;
        w_waddr   = ZZ_NAT[w_p[5:0]];
        w_pos_nxt = w_p + 7'd1;
        w_finish  = (w_p == 7'd63);
      end
      if (w_finish) w_pos_nxt = '0;
    end

    if (w_rel)    w_full_nxt[r_rd_bank] = 1'b0;
    if (w_finish) w_full_nxt[r_wr_bank] = 1'b1;
  end

  // Control state, predictors, valid masks and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos       <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_full      <= '0;
      r_mask[0]   <= '0;
      r_mask[1]   <= '0;
      r_bank_comp[0] <= '0;
      r_bank_comp[1] <= '0;
      r_bank_qtb[0]  <= 1'b0;
      r_bank_qtb[1]  <= 1'b0;
      r_blk_valid <= 1'b0;
      r_blk_comp  <= '0;
      r_blk_qtb   <= 1'b0;
      r_rd_data   <= '0;
      r_err       <= 1'b0;
      for (int unsigned k = 0; k < NCOMP; k++) r_pred[k] <= '0;
    end else begin
      r_pos       <= w_pos_nxt;
      r_full      <= w_full_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_blk_valid <= w_full_nxt[w_rd_bank_nxt];
      r_blk_comp  <= w_full_nxt[w_rd_bank_nxt] ? r_bank_comp[w_rd_bank_nxt] : '0;
      r_blk_qtb   <= w_full_nxt[w_rd_bank_nxt] & r_bank_qtb[w_rd_bank_nxt];
      if (w_finish) r_wr_bank <= ~r_wr_bank;
      if ((bus.sym_valid && w_stall) || w_ovf) r_err <= 1'b1;

      if (bus.clr_pred) begin
        for (int unsigned k = 0; k < NCOMP; k++) r_pred[k] <= '0;
      end
      // The mask is cleared when the DC lands, not at finish, so a bank
      // still awaiting release is never wiped.
      if (w_dc_wr) begin
        if (w_pred_ok) r_pred[bus.data_type] <= w_dc;
        r_mask[r_wr_bank]      <= 64'd1;
        r_bank_comp[r_wr_bank] <= bus.data_type;
        r_bank_qtb[r_wr_bank]  <= bus.quan_tb_sel;
      end
      if (w_wr_ac) r_mask[r_wr_bank][w_waddr] <= 1'b1;

      r_rd_data <= r_mask[r_rd_bank][bus.rd_addr] ? r_mem[r_rd_bank][bus.rd_addr] : '0;
    end
  end

  // Block RAM storage; entries are qualified by the valid mask.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_bank][w_waddr] <= w_wdata;
  end

  assign bus.stall     = w_stall;
  assign bus.blk_valid = r_blk_valid;
  assign bus.blk_comp  = r_blk_comp;
  assign bus.blk_qtb   = r_blk_qtb;
  assign bus.rd_data   = r_rd_data;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_huff_coef_unpack.sv
// Scoreboard bench for huff_coef_unpack: symbols are pushed through a
// behavioural model that queues expected blocks; a reader process drains
// completed blocks from the DUT and compares them.
module tb_huff_coef_unpack;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  huff_coef_unpack_if #(.COEF_W(16)) bus ();
  huff_coef_unpack #(.COEF_W(16), .NCOMP(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // model state
  int   zz [64];
  int   m_blk [64];
  int   m_pos = 0;
  int   m_pred [3];
  int   m_comp = 0;
  int   m_qtb = 0;
  logic m_err = 1'b0;
  logic [2:0]  q_meta [$];
  logic [15:0] q_coef [$];

  bit rd_en = 1'b1;
  bit skip_one = 1'b0;
  bit rd_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Zigzag order by walking anti-diagonals of the 8x8 block.
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int rmin = (s > 7) ? s - 7 : 0;
      int rmax = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = rmax; r >= rmin; r--) begin zz[k] = r * 8 + (s - r); k++; end
      else            for (int r = rmin; r <= rmax; r++) begin zz[k] = r * 8 + (s - r); k++; end
    end
  endfunction

  function automatic int model_ext(input logic [31:0] st, input int hs, input int len);
    longint unsigned val;
    if (len == 0) return 0;
    val = ({32'd0, st} >> (31 - hs - len)) & ((64'd1 << len) - 64'd1);
    if (val < (64'd1 << (len - 1))) return int'(val) - ((1 << len) - 1);
    return int'(val);
  endfunction

  function automatic logic [31:0] mk_stream(input int hs, input int len, input int bits);
    logic [31:0] st = $urandom;
    int lo = 31 - hs - len;
    for (int i = 0; i < len; i++) st[lo + i] = bits[i];
    return st;
  endfunction

  function automatic void model_finish();
    q_meta.push_back({2'(m_comp), 1'(m_qtb)});
    for (int i = 0; i < 64; i++) begin q_coef.push_back(16'(m_blk[i])); m_blk[i] = 0; end
    m_pos = 0;
  endfunction

  function automatic void model_sym(input int hs, input int zero, input int len,
                                    input logic [31:0] st, input int typ, input int qtb, input int clr);
    int v = model_ext(st, hs, len);
    if (clr != 0) for (int c = 0; c < 3; c++) m_pred[c] = 0;
    if (m_pos == 0) begin
      int p = (typ == 3) ? 0 : m_pred[typ];
      int coef = int'(16'(p + v));
      if (typ != 3) m_pred[typ] = coef;
      m_blk[0] = coef; m_comp = typ; m_qtb = qtb; m_pos = 1;
    end else if (len == 0 && zero == 0) begin
      model_finish();
    end else if (len == 0 && zero == 15) begin
      if (m_pos + 16 > 63) begin m_err = 1'b1; model_finish(); end
      else m_pos += 16;
    end else if (m_pos + zero > 63) begin
      m_err = 1'b1; model_finish();
    end else begin
      m_blk[zz[m_pos + zero]] = v;
      m_pos = m_pos + zero + 1;
      if (m_pos == 64) model_finish();
    end
  endfunction

  task automatic send(input int hs, input int zero, input int len, input logic [31:0] st,
                      input int typ, input int qtb, input int clr);
    int n = 0;
    @(negedge clk);
    while (bus.stall && n < 3000) begin @(negedge clk); n++; end
    if (bus.stall) begin chk("stall_timeout", 32'd1, 32'd0); return; end
    @(posedge clk); #1;
    bus.huff_size = 4'(hs); bus.data_zero = 4'(zero); bus.data_len = 4'(len);
    bus.data_stream = st; bus.data_type = 2'(typ); bus.quan_tb_sel = 1'(qtb);
    bus.clr_pred = 1'(clr); bus.sym_valid = 1'b1;
    @(posedge clk); #1;
    bus.sym_valid = 1'b0; bus.clr_pred = 1'b0;
    model_sym(hs, zero, len, st, typ, qtb, clr);
  endtask

  task automatic dc(input int typ, input int qtb, input int len, input int bits, input int clr);
    int hs = $urandom_range(15);
    send(hs, 0, len, mk_stream(hs, len, bits), typ, qtb, clr);
  endtask

  task automatic ac(input int zero, input int len, input int bits);
    int hs = $urandom_range(15);
    send(hs, zero, len, mk_stream(hs, len, bits), 0, 0, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q_meta.size() != 0 || rd_busy || bus.blk_valid) && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("drain_timeout", 32'(n >= 20000), 32'd0);
  endtask

  // Monitor: compare each completed block against the scoreboard, then release it.
  initial begin : reader
    logic [2:0]  meta;
    logic [15:0] ec;
    bus.rd_addr = '0;
    bus.blk_release = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.blk_valid && (rd_en || skip_one)) begin
        rd_busy = 1'b1;
        if (q_meta.size() == 0) begin
          chk("unexpected_block", 32'd1, 32'd0);
        end else begin
          meta = q_meta.pop_front();
          if (skip_one) begin
            for (int a = 0; a < 64; a++) ec = q_coef.pop_front();
          end else begin
            chk("blk_comp", 32'(bus.blk_comp), 32'(meta[2:1]));
            chk("blk_qtb", 32'(bus.blk_qtb), 32'(meta[0]));
            for (int a = 0; a < 64; a++) begin
              @(posedge clk); #1 bus.rd_addr = 6'(a);
              @(posedge clk); #1;
              ec = q_coef.pop_front();
              chk($sformatf("coef[%0d]", a), 32'(bus.rd_data), 32'(ec));
            end
          end
        end
        @(posedge clk); #1 bus.blk_release = 1'b1;
        @(posedge clk); #1 bus.blk_release = 1'b0;
        skip_one = 1'b0;
        repeat ($urandom_range(3)) @(posedge clk);
        rd_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    build_zz();
    for (int i = 0; i < 64; i++) m_blk[i] = 0;
    for (int c = 0; c < 3; c++) m_pred[c] = 0;
    bus.sym_valid = 1'b0; bus.huff_size = '0; bus.data_zero = '0; bus.data_len = '0;
    bus.data_stream = '0; bus.data_type = '0; bus.quan_tb_sel = 1'b0; bus.clr_pred = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_blk_valid", 32'(bus.blk_valid), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_blk_comp", 32'(bus.blk_comp), 32'd0);
    chk("rst_blk_qtb", 32'(bus.blk_qtb), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // DC-only comp0 (101 -> 5), predicted comp0 (010 -> -5), comp1 independent
    send(1, 0, 3, mk_stream(1, 3, 3'b101), 0, 0, 0);
    ac(0, 0, 0);
    dc(0, 0, 3, 3'b010, 0); ac(0, 0, 0);
    dc(1, 1, 3, 3'b010, 0); ac(0, 0, 0);
    // AC run to zigzag index 3
    dc(2, 0, 2, 2'b11, 0); ac(2, 1, 1); ac(0, 0, 0);
    // three ZRLs then run 14 fills natural 63 and finishes without EOB
    dc(0, 1, 0, 0, 0); ac(15, 0, 0); ac(15, 0, 0); ac(15, 0, 0); ac(14, 1, 0);
    drain();
    chk("err_after_fill63", 32'(bus.err), 32'(m_err));

    // stall: two finished blocks with no release
    rd_en = 1'b0;
    dc(1, 0, 4, 4'b1001, 0); ac(0, 0, 0);
    dc(2, 1, 4, 4'b0110, 0); ac(0, 0, 0);
    @(negedge clk);
    chk("stall_both_full", 32'(bus.stall), 32'd1);
    chk("stall_blk_valid", 32'(bus.blk_valid), 32'd1);
    chk("stall_blk_comp", 32'(bus.blk_comp), 32'd1);
    chk("stall_err_before", 32'(bus.err), 32'd0);
    @(posedge clk); #1 bus.data_type = 2'd0; bus.data_len = 4'd3; bus.sym_valid = 1'b1;
    @(posedge clk); #1 bus.sym_valid = 1'b0;
    m_err = 1'b1;
    @(negedge clk);
    chk("drop_err", 32'(bus.err), 32'(m_err));
    skip_one = 1'b1;
    n = 0;
    while (skip_one && n < 200) begin @(negedge clk); n++; end
    chk("release_timeout", 32'(skip_one), 32'd0);
    chk("release_stall", 32'(bus.stall), 32'd0);
    chk("release_blk_valid", 32'(bus.blk_valid), 32'd1);
    chk("release_blk_comp", 32'(bus.blk_comp), 32'd2);
    chk("release_blk_qtb", 32'(bus.blk_qtb), 32'd1);
    rd_en = 1'b1;

    // run overflow: ZRL x3 then run 15
    dc(0, 0, 1, 1, 0); ac(15, 0, 0); ac(15, 0, 0); ac(15, 0, 0); ac(15, 1, 0);
    drain();
    chk("err_overflow", 32'(bus.err), 32'(m_err));

    // randomized blocks
    for (int b = 0; b < 20; b++) begin
      int typ = $urandom_range(3);
      int qtb = $urandom_range(1);
      int clr = ($urandom_range(7) == 0) ? 1 : 0;
      send($urandom_range(15), 0, $urandom_range(11), $urandom, typ, qtb, clr);
      while (m_pos != 0) begin
        int r = $urandom_range(9);
        if (r == 0) ac(0, 0, 0);
        else if (r == 1 && m_pos + 16 <= 63) ac(15, 0, 0);
        else begin
          int zmax = (63 - m_pos < 14) ? 63 - m_pos : 14;
          int zero = $urandom_range(zmax);
          int len = $urandom_range(15);
          if (len == 0 && zero == 0) len = 1;
          send($urandom_range(15), zero, len, $urandom, 0, 0, 0);
        end
      end
    end
    drain();

    // reset mid-block, then an unpredicted DC
    dc(0, 0, 3, 3'b111, 0); ac(1, 2, 2'b10);
    @(posedge clk); #1 rst = 1'b0;
    m_pos = 0; m_err = 1'b0;
    for (int c = 0; c < 3; c++) m_pred[c] = 0;
    for (int i = 0; i < 64; i++) m_blk[i] = 0;
    @(negedge clk);
    chk("midrst_blk_valid", 32'(bus.blk_valid), 32'd0);
    chk("midrst_stall", 32'(bus.stall), 32'd0);
    chk("midrst_err", 32'(bus.err), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    dc(0, 0, 3, 3'b101, 0); ac(0, 0, 0);
    drain();
    chk("err_final", 32'(bus.err), 32'(m_err));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
